// File: rtl/box_painter.sv
// box_painter: expands one box request (top-left x/y, colour) into a raster of
// BOX_W x BOX_H single-pixel writes for the VGA adapter, one pixel per cycle,
// clipping pixels that fall outside the visible screen.
module box_painter #(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 2,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic       in_ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last column/row index of the box; counters are 3 bits since boxes are at most 8x8.
  localparam logic [2:0] COL_MAX = 3'(BOX_W - 1);
  localparam logic [2:0] ROW_MAX = 3'(BOX_H - 1);
  // Visible limits at the width of the unclipped sums, so off-screen sums never wrap in.
  localparam logic [8:0] SCR_W   = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H   = 8'(SCREEN_H);

  state_t     state_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic [2:0] col_q;
  logic [2:0] row_q;
  logic       ready_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] vga_colour_q;
  logic       vga_plot_q;
  logic       busy_q;
  logic       done_q;

  logic [2:0] col_d;
  logic [2:0] row_d;
  logic       last_pixel;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] off_col;
  logic [2:0] off_row;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       plot_ok;

  // Raster stepping: column fastest, row next; last_pixel flags the final pixel on show.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    last_pixel = 1'b0;
    if (col_q != COL_MAX) begin
      col_d = col_q + 3'd1;
    end else begin
      col_d = 3'd0;
      if (row_q != ROW_MAX) begin
        row_d = row_q + 3'd1;
      end else begin
        last_pixel = 1'b1;
      end
    end
  end

  // Coordinates of the pixel to be presented next cycle: the corner on accept,
  // otherwise the registered corner plus the stepped counters. Sums are kept wide
  // so that clipping is decided before truncation.
  always_comb begin
    if (state_q == DRAW) begin
      base_x  = x_q;
      base_y  = y_q;
      off_col = col_d;
      off_row = row_d;
    end else begin
      base_x  = in_x;
      base_y  = in_y;
      off_col = 3'd0;
      off_row = 3'd0;
    end
    sum_x   = {1'b0, base_x} + {6'b0, off_col};
    sum_y   = {1'b0, base_y} + {5'b0, off_row};
    plot_ok = (sum_x < SCR_W) && (sum_y < SCR_H);
  end

  // Control FSM with registered pixel, handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      col_q        <= 3'd0;
      row_q        <= 3'd0;
      ready_q      <= 1'b1;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          vga_plot_q <= 1'b0;
          done_q     <= 1'b0;
          if (in_valid && ready_q) begin
            x_q          <= in_x;
            y_q          <= in_y;
            colour_q     <= in_colour;
            col_q        <= 3'd0;
            row_q        <= 3'd0;
            vga_x_q      <= sum_x[7:0];
            vga_y_q      <= sum_y[6:0];
            vga_colour_q <= in_colour;
            vga_plot_q   <= plot_ok;
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= DRAW;
          end
        end
        DRAW: begin
          if (last_pixel) begin
            vga_plot_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            vga_x_q      <= sum_x[7:0];
            vga_y_q      <= sum_y[6:0];
            vga_colour_q <= colour_q;
            vga_plot_q   <= plot_ok;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          col_q   <= 3'd0;
          row_q   <= 3'd0;
          state_q <= IDLE;
        end
        default: begin
          vga_plot_q <= 1'b0;
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
